// File: rtl/cp0_ctrl_param_if.sv
// Commit-stage bus between the pipeline and coprocessor 0: mtc0/mfc0 access,
// exception/eret strobes and the control outputs returned to the PC unit.
interface cp0_ctrl_param_if;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_pc;
    logic        eret;
    logic        int_req;
    logic        take;
    logic [31:0] epc_out;
    logic        exl_out;

    modport master (
        output we, addr, wdata, exc_req, exc_code, exc_bd, exc_pc, eret,
        input  rdata, int_req, take, epc_out, exl_out
    );

    modport slave (
        input  we, addr, wdata, exc_req, exc_code, exc_bd, exc_pc, eret,
        output rdata, int_req, take, epc_out, exl_out
    );
endinterface

// File: rtl/cp0_ctrl_param.sv
// Coprocessor 0 (SR, Cause, EPC, PRId) with interrupt/exception arbitration at the M/W commit point.
// Optional Count/Compare timer is built when the macro CP0_TIMER_EN is defined.
module cp0_ctrl_param #(
    parameter int unsigned NUM_HWINT = 6,
    parameter logic [31:0] PRID_VAL  = 32'h1817_1906,
    parameter int unsigned TIMER_DIV = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_HWINT-1:0] hw_int,
    cp0_ctrl_param_if.slave      bus
);
    if (NUM_HWINT < 1 || NUM_HWINT > 6) begin : g_bad_num_hwint
        $error("NUM_HWINT must be in 1..6");
    end
    if (TIMER_DIV < 1 || TIMER_DIV > 255) begin : g_bad_timer_div
        $error("TIMER_DIV must be in 1..255");
    end

    typedef enum logic {
        MODE_NORMAL = 1'b0,
        MODE_EXC    = 1'b1
    } mode_t;

    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_SR      = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;
    localparam logic [4:0] A_PRID    = 5'd15;

    mode_t                mode_r;
    logic                 ie_r;
    logic [NUM_HWINT-1:0] im_r;
    logic [NUM_HWINT-1:0] ip_r;
    logic                 bd_r;
    logic [4:0]           code_r;
    logic [31:0]          epc_r;

    logic [NUM_HWINT-1:0] timer_ip_s;
    logic [NUM_HWINT-1:0] ip_eff_s;
    logic                 exl_s;
    logic                 int_req_s;
    logic                 take_s;
    logic [4:0]           code_sel_s;
    logic [31:0]          epc_base_s;
    logic [31:0]          epc_next_s;
    logic [31:0]          sr_rd_s;
    logic [31:0]          cause_rd_s;
    logic [31:0]          count_rd_s;
    logic [31:0]          compare_rd_s;
    logic [31:0]          rdata_s;

    assign exl_s      = (mode_r == MODE_EXC);
    assign ip_eff_s   = ip_r | timer_ip_s;
    assign int_req_s  = ie_r & ~exl_s & (|(ip_eff_s & im_r));
    assign take_s     = int_req_s | bus.exc_req;
    assign code_sel_s = int_req_s ? 5'd0 : bus.exc_code;
    // A delay-slot instruction restarts at its branch, one word earlier.
    assign epc_base_s = bus.exc_pc & 32'hFFFF_FFFC;
    assign epc_next_s = bus.exc_bd ? (epc_base_s - 32'd4) : epc_base_s;

`ifdef CP0_TIMER_EN
    localparam logic [7:0] DIV_LAST = 8'(TIMER_DIV - 1);

    logic [7:0]  pre_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        pend_r;
    logic        mtc0_s;
    logic        tick_s;
    logic        cnt_wr_s;
    logic        cmp_wr_s;
    logic [31:0] count_inc_s;

    assign mtc0_s      = bus.we & ~take_s & ~bus.eret;
    assign cnt_wr_s    = mtc0_s & (bus.addr == A_COUNT);
    assign cmp_wr_s    = mtc0_s & (bus.addr == A_COMPARE);
    assign tick_s      = (pre_r == DIV_LAST);
    assign count_inc_s = count_r + 32'd1;

    // Prescaled Count, Compare and the sticky timer-pending flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_r     <= 8'd0;
            count_r   <= 32'd0;
            compare_r <= 32'hFFFF_FFFF;
            pend_r    <= 1'b0;
        end else begin
            if (cnt_wr_s) begin
                count_r <= bus.wdata;
                pre_r   <= 8'd0;
            end else if (tick_s) begin
                count_r <= count_inc_s;
                pre_r   <= 8'd0;
            end else begin
                pre_r   <= pre_r + 8'd1;
            end
            if (cmp_wr_s) begin
                compare_r <= bus.wdata;
                pend_r    <= 1'b0;
            end else if (!cnt_wr_s && tick_s && (count_inc_s == compare_r)) begin
                pend_r    <= 1'b1;
            end else begin
                pend_r    <= pend_r;
            end
        end
    end

    assign timer_ip_s   = pend_r ? (NUM_HWINT'(1) << (NUM_HWINT - 1)) : '0;
    assign count_rd_s   = count_r;
    assign compare_rd_s = compare_r;
`else
    assign timer_ip_s   = '0;
    assign count_rd_s   = 32'd0;
    assign compare_rd_s = 32'd0;
`endif

    // Assemble the architectural views of SR and Cause.
    always_comb begin
        sr_rd_s                  = 32'd0;
        sr_rd_s[10 +: NUM_HWINT] = im_r;
        sr_rd_s[1]               = exl_s;
        sr_rd_s[0]               = ie_r;
        cause_rd_s                  = 32'd0;
        cause_rd_s[31]              = bd_r;
        cause_rd_s[10 +: NUM_HWINT] = ip_eff_s;
        cause_rd_s[6:2]             = code_r;
    end

    // mfc0 read mux; shows state before this cycle's update.
    always_comb begin
        rdata_s = 32'd0;
        case (bus.addr)
            A_COUNT:   rdata_s = count_rd_s;
            A_COMPARE: rdata_s = compare_rd_s;
            A_SR:      rdata_s = sr_rd_s;
            A_CAUSE:   rdata_s = cause_rd_s;
            A_EPC:     rdata_s = epc_r;
            A_PRID:    rdata_s = PRID_VAL;
            default:   rdata_s = 32'd0;
        endcase
    end

    // Mode machine and CP0 state: take beats eret, eret beats mtc0.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r <= MODE_NORMAL;
            ie_r   <= 1'b1;
            im_r   <= '1;
            ip_r   <= '0;
            bd_r   <= 1'b0;
            code_r <= 5'd0;
            epc_r  <= 32'd0;
        end else begin
            ip_r <= hw_int;
            if (take_s) begin
                code_r <= code_sel_s;
                if (mode_r == MODE_NORMAL) begin
                    mode_r <= MODE_EXC;
                    bd_r   <= bus.exc_bd;
                    epc_r  <= epc_next_s;
                end
            end else if (bus.eret) begin
                mode_r <= MODE_NORMAL;
            end else if (bus.we) begin
                case (bus.addr)
                    A_SR: begin
                        im_r   <= bus.wdata[10 +: NUM_HWINT];
                        ie_r   <= bus.wdata[0];
                        mode_r <= bus.wdata[1] ? MODE_EXC : MODE_NORMAL;
                    end
                    A_EPC:   epc_r <= bus.wdata & 32'hFFFF_FFFC;
                    default: epc_r <= epc_r;
                endcase
            end
        end
    end

    assign bus.rdata   = rdata_s;
    assign bus.int_req = int_req_s;
    assign bus.take    = take_s;
    assign bus.epc_out = epc_r;
    assign bus.exl_out = exl_s;
endmodule

// File: doc/cp0_ctrl_param.md
Name: cp0_ctrl_param

Overview:
- Parametrised coprocessor-0 for the pipelined MIPS core. Holds SR, Cause, EPC and PRId.
- Registers interrupt-pending state, arbitrates interrupts against synchronous exceptions, and supplies the EPC/eret target to the PC unit.
- Commit point is the M/W boundary: exception, eret and mtc0 strobes are presented there, one instruction per cycle.

Parameters:
NUM_HWINT, 6, number of hardware interrupt lines (1..6); mapped to Cause.IP/SR.IM bits [10 +: NUM_HWINT]
PRID_VAL, 32'h1817_1906, constant read from PRId
TIMER_DIV, 1, Count increments once every TIMER_DIV cycles (1..255); used only with CP0_TIMER_EN

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
we  in  1  mtc0 commit strobe
addr  in  5  CP0 register number for mtc0/mfc0
wdata  in  32  mtc0 data
rdata  out  32  mfc0 read data, combinational from addr
hw_int  in  NUM_HWINT  level-sensitive external interrupt lines
exc_req  in  1  synchronous exception at commit
exc_code  in  5  ExcCode of exc_req
exc_bd  in  1  committing instruction is in a delay slot
exc_pc  in  32  PC of the committing instruction
eret  in  1  eret commit strobe
int_req  out  1  interrupt will be taken this cycle
take  out  1  exception or interrupt taken this cycle; pipeline flushes, PC goes to handler
epc_out  out  32  current EPC register value (eret target)
exl_out  out  1  SR.EXL

Behaviour:
- Register map:
  - SR(12): IM[10 +: N] r/w, EXL bit1 r/w, IE bit0 r/w; other bits read 0.
  - Cause(13): BD bit31, IP[10 +: N], ExcCode[6:2]; read-only.
  - EPC(14): r/w; bits[1:0] are always stored as 0.
  - PRId(15): read-only.
  - Any other addr reads 0; writes to it are ignored.
- Reset values:
  - SR: IM all 1, EXL=0, IE=1.
  - Cause = 0; EPC = 0.
  - Outputs at reset: take=0, int_req=0, rdata per addr.
- IP sampling: IP bits register hw_int every cycle (1-cycle latency); no sticky latching of hw_int.
- int_req = IE & ~EXL & |(IP & IM), combinational from registered state.
- take = int_req | exc_req.
- Priority, per cycle: take > eret > mtc0.
  - A mtc0 or eret coincident with take is dropped.
  - Interrupt wins over exc_req: ExcCode=0. Otherwise ExcCode = exc_code.
- On take with EXL=0 (two-state mode machine, NORMAL -> EXC):
  - EXL <= 1.
  - BD <= exc_bd.
  - EPC <= exc_bd ? {exc_pc[31:2],2'b0} - 4 : {exc_pc[31:2],2'b0}.
  - ExcCode updated.
- On take with EXL=1: only exc_req can occur here. ExcCode is updated; EPC and BD are held.
- eret (EXC -> NORMAL): EXL <= 0.
- mtc0 to SR may set or clear EXL directly.
- EPC arithmetic wraps modulo 2^32 (exc_pc=0 in a delay slot gives 32'hFFFF_FFFC).
- rdata reflects register state before the current cycle's update; there is no write-through bypass.
- Reset mid-exception clears EXL and pending state unconditionally.

Optional Feature:
- Macro: CP0_TIMER_EN.
- When defined:
  - Count(9) r/w, reset 0. Increments every TIMER_DIV cycles using an 8-bit prescaler that resets to 0 on any Count write.
  - Compare(11) r/w, reset 32'hFFFF_FFFF.
  - When Count == Compare after an increment, a sticky timer-pending bit is set. It is cleared only by a write to Compare.
  - The timer-pending bit is ORed into IP line NUM_HWINT-1 (after IP sampling).
  - A mtc0 write to Count in the same cycle as an increment takes precedence over the increment.
- When undefined: addrs 9/11 read 0, writes are ignored, and no timer logic is generated.

Test Plan:
- Reset, then read 12/13/14/15 -> 32'h0000_FC01, 0, 0, 32'h1817_1906.
- hw_int=6'b000100 held -> int_req=1 one cycle later. With exc_pc=32'h0000_3008, exc_bd=0: EPC=32'h3008, Cause=32'h0000_1000, EXL=1, int_req drops next cycle.
- exc_req with exc_code=5'd10, exc_bd=1, exc_pc=32'h3010 -> EPC=32'h300C, Cause=32'h8000_0028. A second exc_req while EXL=1 with code 12 -> ExcCode=12, EPC still 32'h300C.
- eret and mtc0 EPC=32'h4003 in the same cycle as take -> both dropped. mtc0 EPC=32'h4003 alone -> reads 32'h4000. eret alone -> EXL=0.
- mtc0 SR=0 (IE=0) with hw_int asserted -> int_req stays 0. Rewrite SR=32'h0000_FC01 -> int_req=1 next cycle.
- CP0_TIMER_EN, TIMER_DIV=1: write Compare=5, Count=0 -> IP[15]=1 after Count reaches 5; stays set until Compare is written.
